shared_reg_arbiter: RTL and testbench
=====================================

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the number of requesters (2..8).
REQ-002 The module SHALL have parameter W, default 8, giving the shared register data width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the posedge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port req, input, N bits: per-requester write request, held high until that requester's gnt is seen.
REQ-006 The module SHALL have port wdata, input, N*W bits: requester i's data in bits [i*W +: W].
REQ-007 The module SHALL have port gnt, output, N bits: one-hot grant pulse, registered.
REQ-008 The module SHALL have port q, output, W bits: shared register contents.
REQ-009 The module SHALL have port q_valid, output, 1 bit: q has been written since reset.
REQ-010 The module SHALL have port owner, output, clog2(N) bits: index of the last writer.
REQ-011 The module SHALL have port wr_count, output, 16 bits: count of completed writes, saturating.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and GAP.
REQ-013 In IDLE with req != 0, the next edge SHALL select a winner by round-robin, searching upward from ptr modulo N, where ptr is the priority pointer.
REQ-014 On that same edge the block SHALL:
  - set gnt = one-hot(winner) for exactly one cycle;
  - load q <= wdata[winner];
  - set owner <= winner and q_valid <= 1;
  - set ptr <= (winner+1) mod N;
  - go to GAP.
REQ-015 In IDLE with req == 0, all state SHALL hold and gnt SHALL be 0.
REQ-016 In GAP, gnt SHALL be 0, req SHALL be ignored, and the next edge SHALL return to IDLE; one write can occur at most every 2 cycles.
REQ-017 Latency from req rising while in IDLE to gnt high SHALL be 1 cycle; q SHALL show the new data in the same cycle gnt is high.
REQ-018 With simultaneous requests, the requester at or after ptr SHALL win; losers SHALL keep req high and SHALL be served in round-robin order.
REQ-019 ptr SHALL wrap from N-1 to 0.
REQ-020 wr_count SHALL increment by 1 per grant and SHALL saturate at 16'hFFFF without wrapping.
REQ-021 A req bit deasserted before its grant SHALL simply not be considered; no error state exists.
REQ-022 gnt SHALL never have more than one bit set.

Reset
REQ-023 While rst_n = 0, the block SHALL force state = IDLE, gnt = 0, q = 0, q_valid = 0, owner = 0, ptr = 0 and wr_count = 0, independent of clk.
REQ-024 Reset asserted mid-GAP or during a gnt cycle SHALL abort immediately; the first grant after release SHALL occur no earlier than the first posedge with rst_n = 1.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (IDLE, GAP) and the wr_count width constant (16).
REQ-026 The round-robin winner selection SHALL be a separate combinational sub-module rr_pick (inputs req and ptr; outputs winner index and any_req).
REQ-027 The storage SHALL be plain posedge D flip-flops with asynchronous clear.
REQ-028 No latches SHALL be inferred.

Verification
REQ-029 Reset: drive rst_n = 0 mid-run with q = 8'h5A -> q = 0, q_valid = 0, gnt = 0, wr_count = 0 immediately, before the next clock edge.
REQ-030 Single request: req = 4'b0100, wdata[2] = 8'h3C -> gnt = 4'b0100 one cycle later for one cycle, q = 8'h3C, owner = 2, q_valid = 1, wr_count = 1.
REQ-031 All requesting: req = 4'b1111 held from reset -> grants go to 0, 1, 2, 3, 0 on cycles 1, 3, 5, 7, 9, each a single-cycle pulse.
REQ-032 Pointer wrap: ptr = 3 after a grant to 2, then req = 4'b1001 -> requester 3 wins, then requester 0.
REQ-033 Back-to-back: requester 1 keeps req high through its gnt and into GAP -> no second grant during GAP; re-grant only after IDLE, if it is still the round-robin winner.
REQ-034 Saturation: preload or run 65535 writes, then one more grant -> wr_count stays 16'hFFFF.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and constants for the shared-register arbiter.
// No logic; this file only holds declarations.
// Nothing here applies backpressure.
package shared_reg_arbiter_pkg;

    // Two-state control: IDLE may grant, GAP enforces one dead cycle after a write.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    // Width of the saturating completed-write counter.
    localparam int CNT_W = 16;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin winner picker: the first set req bit at or above ptr, wrapping modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; any_req flags whether the winner output is meaningful.
module rr_pick #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          any_req
);

    logic found;
    int   idx;

    assign any_req = |req;

    // Walk the requesters starting at ptr; the first active one wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[PW-1:0]]) begin
                winner = idx[PW-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// N requesters share one W-bit register; round-robin arbitration, at most one write per 2 cycles.
// Latency: gnt, q, owner and q_valid update on the edge after req is seen in IDLE.
// Backpressure: losers hold req until their gnt pulse; req is ignored during the GAP cycle.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int PW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   wdata,
    output logic [N-1:0]     gnt,
    output logic [W-1:0]     q,
    output logic             q_valid,
    output logic [PW-1:0]    owner,
    output logic [CNT_W-1:0] wr_count
);

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;
    logic             any_req;
    logic             grant_now;
    logic [PW-1:0]    ptr_nxt;
    logic [CNT_W-1:0] cnt_q;

    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign grant_now = (state == IDLE) && any_req;
    assign ptr_nxt   = (winner == PW'(N - 1)) ? '0 : winner + PW'(1);
    assign wr_count  = cnt_q;

    // Control: a grant sends us to GAP, which always returns to IDLE next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (state == GAP) begin
            state <= IDLE;
        end else if (grant_now) begin
            state <= GAP;
        end
    end

    // Register, owner, pointer and the single-cycle grant pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
            ptr     <= '0;
        end else begin
            gnt <= '0;
            if (grant_now) begin
                gnt     <= {{(N-1){1'b0}}, 1'b1} << winner;
                q       <= wdata[winner*W +: W];
                q_valid <= 1'b1;
                owner   <= winner;
                ptr     <= ptr_nxt;
            end
        end
    end

    // Completed-write counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (grant_now && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: rule-level model compared every cycle, plus directed literal checks.
// Grants are logged with the cycle number (posedges since reset release) for sequence checks.
// Terminates on its own after a fixed directed sequence.
module tb_shared_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int PW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [PW-1:0]  owner;
    logic [15:0]    wr_count;

    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .q        (q),
        .q_valid  (q_valid),
        .owner    (owner),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: a write may happen on any edge not immediately following a write;
    // the winner is the first requester found counting up from the pointer, modulo N.
    logic [N-1:0] m_gnt;
    logic [W-1:0] m_q;
    logic         m_valid;
    int           m_owner;
    int           m_ptr;
    int           m_cnt;
    int           cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_gnt = '0; m_q = '0; m_valid = 1'b0;
            m_owner = 0; m_ptr = 0; m_cnt = 0; cyc = 0;
        end else begin
            int w;
            cyc++;
            w = -1;
            if (m_gnt == '0) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
            end
            if (w >= 0) begin
                m_gnt   = '0;
                m_gnt[w] = 1'b1;
                m_q     = wdata[w*W +: W];
                m_valid = 1'b1;
                m_owner = w;
                m_ptr   = (w + 1) % N;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_gnt = '0;
            end
        end
    end

    // Grant log: requester index and cycle of each observed pulse.
    int log_idx[$];
    int log_cyc[$];

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("q", 32'(q), 32'(m_q));
        check("q_valid", 32'(q_valid), 32'(m_valid));
        check("owner", 32'(owner), 32'(m_owner));
        check("wr_count", 32'(wr_count), 32'(m_cnt));
        check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                log_idx.push_back(i);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic set_wd(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        log_idx.delete();
        log_cyc.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        wdata = '0;
        #1;
        check("rst_q", 32'(q), 32'h0);
        check("rst_gnt", 32'(gnt), 32'h0);

        // All requesting, held from reset: grants 0,1,2,3,0 on cycles 1,3,5,7,9.
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_wd(i, 8'(8'h10 + i));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        req = '0;
        #1;
        check("rr_count", 32'(log_idx.size()), 32'd5);
        if (log_idx.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("rr_idx", 32'(log_idx[i]), 32'(i % 4));
                check("rr_cyc", 32'(log_cyc[i]), 32'(2 * i + 1));
            end
        end

        // Single request from requester 2.
        do_reset();
        set_wd(2, 8'h3C);
        req = 4'b0100;
        @(negedge clk); #1;
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_q", 32'(q), 32'h3C);
        check("single_owner", 32'(owner), 32'd2);
        check("single_valid", 32'(q_valid), 32'd1);
        check("single_cnt", 32'(wr_count), 32'd1);
        req = '0;
        @(negedge clk); #1;
        check("single_pulse_end", 32'(gnt), 32'h0);

        // Pointer now 3: requesters 3 and 0 -> 3 first, then 0 after the gap.
        set_wd(3, 8'hA3);
        set_wd(0, 8'hB0);
        req = 4'b1001;
        @(negedge clk); #1;
        check("wrap_first", 32'(owner), 32'd3);
        check("wrap_first_q", 32'(q), 32'hA3);
        req = 4'b0001;
        repeat (2) @(negedge clk); #1;
        check("wrap_second", 32'(owner), 32'd0);
        check("wrap_second_gnt", 32'(gnt), 32'h1);
        req = '0;

        // Requester 1 holds req continuously: re-grants only every second cycle.
        @(negedge clk); #1;
        log_idx.delete();
        log_cyc.delete();
        set_wd(1, 8'h77);
        req = 4'b0010;
        repeat (5) @(negedge clk); #1;
        req = '0;
        repeat (2) @(negedge clk); #1;
        check("b2b_count", 32'(log_idx.size()), 32'd3);
        if (log_idx.size() == 3) begin
            for (int i = 0; i < 3; i++) check("b2b_idx", 32'(log_idx[i]), 32'd1);
            check("b2b_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
            check("b2b_gap2", 32'(log_cyc[2] - log_cyc[1]), 32'd2);
        end

        // Reset asserted during a grant cycle clears everything before the next edge.
        set_wd(0, 8'h5A);
        req = 4'b0001;
        @(negedge clk); #1;
        check("pre_rst_q", 32'(q), 32'h5A);
        check("pre_rst_gnt", 32'(gnt), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_q", 32'(q), 32'h0);
        check("async_valid", 32'(q_valid), 32'h0);
        check("async_gnt", 32'(gnt), 32'h0);
        check("async_cnt", 32'(wr_count), 32'h0);
        check("async_owner", 32'(owner), 32'h0);
        @(negedge clk);
        log_idx.delete();
        log_cyc.delete();
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_grants", 32'(log_idx.size()), 32'd1);
        if (log_idx.size() == 1) check("post_rst_cyc", 32'(log_cyc[0]), 32'd1);
        req = '0;

        // Saturation: counter preset near the top, then two more grants.
        @(negedge clk);
        #2;
        force dut.cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        #1;
        release dut.cnt_q;
        req = 4'b0001;
        @(negedge clk); #1;
        check("sat_reach", 32'(wr_count), 32'hFFFF);
        repeat (2) @(negedge clk); #1;
        check("sat_gnt", 32'(gnt), 32'h1);
        check("sat_hold", 32'(wr_count), 32'hFFFF);
        req = '0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
